// File: rtl/dual_deque_pkg.sv
// Shared definitions for the dual-deque command host: opcodes, response bytes
// and the host FSM state encoding.
package dual_deque_pkg;

  // Opcode field, cmd byte [7:6]
  localparam logic [1:0] OP_STATUS = 2'b00;
  localparam logic [1:0] OP_PUSH   = 2'b01;
  localparam logic [1:0] OP_POP    = 2'b10;
  localparam logic [1:0] OP_MOVE   = 2'b11;

  // Response bytes
  localparam logic [7:0] RSP_PUSH_OK   = 8'h01;
  localparam logic [7:0] RSP_POP_OK    = 8'h02;
  localparam logic [7:0] RSP_MOVE_OK   = 8'h03;
  localparam logic [7:0] RSP_PUSH_FULL = 8'hE1;
  localparam logic [7:0] RSP_POP_EMPTY = 8'hE2;
  localparam logic [7:0] RSP_MOVE_ERR  = 8'hE3;
  localparam logic [7:0] RSP_BAD_OP    = 8'hEF;
  localparam logic [3:0] STATUS_TAG    = 4'h5;

  typedef enum logic [3:0] {
    StIdle,
    StDecode,
    StGetData,
    StCheck,
    StIssuePop,
    StWait,
    StIssuePush,
    StResp,
    StResp2
  } host_state_e;

endpackage

// File: rtl/deque_cmd_host.sv
// Command-side initiator for the dual deque. Accepts opcode/payload bytes on
// the cmd stream, drives the deque strobes, and returns response bytes on the
// rsp stream. Illegal operations are answered with error bytes and never
// strobe the deque.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   cmd_valid/cmd_ready/cmd_data   command byte stream (in)
//   rsp_valid/rsp_ready/rsp_data   response byte stream (out)
//   dq_select/dq_push/dq_pop/dq_data_in   deque control outputs
//   dq_data_out, dq_s{0,1}_{empty,full}   deque data/status inputs
module deque_cmd_host #(
  parameter int unsigned POP_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       dq_select,
  output logic       dq_push,
  output logic       dq_pop,
  output logic [7:0] dq_data_in,
  input  logic [7:0] dq_data_out,
  input  logic       dq_s0_empty,
  input  logic       dq_s0_full,
  input  logic       dq_s1_empty,
  input  logic       dq_s1_full
);
  import dual_deque_pkg::*;

  localparam logic [1:0] WaitInit = 2'(POP_LATENCY - 1);

  host_state_e state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic [7:0]  cap_q, cap_d;        // push payload, or popped data
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        dq_select_q, dq_select_d;
  logic [7:0]  dq_data_in_q, dq_data_in_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        two_q, two_d;        // a second response byte follows RESP

  logic [1:0] op;
  logic       sel;
  logic       tgt_empty, tgt_full, oth_full;

  assign op  = op_q[7:6];
  assign sel = op_q[0];

  // Flags of the selected deque and of the opposite one (MOVE destination)
  assign tgt_empty = sel ? dq_s1_empty : dq_s0_empty;
  assign tgt_full  = sel ? dq_s1_full  : dq_s0_full;
  assign oth_full  = sel ? dq_s0_full  : dq_s1_full;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cap_d        = cap_q;
    rsp_data_d   = rsp_data_q;
    dq_select_d  = dq_select_q;
    dq_data_in_d = dq_data_in_q;
    cnt_d        = cnt_q;
    two_d        = two_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op_d    = cmd_data;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (op_q[5:1] != 5'd0) begin
          rsp_data_d = RSP_BAD_OP;
          two_d      = 1'b0;
          state_d    = StResp;
        end else if (op == OP_PUSH) begin
          state_d = StGetData;
        end else begin
          state_d = StCheck;
        end
      end
      StGetData: begin
        if (cmd_valid) begin
          cap_d   = cmd_data;
          state_d = StCheck;
        end
      end
      StCheck: begin
        two_d   = 1'b0;
        state_d = StResp;
        unique case (op)
          OP_STATUS: begin
            rsp_data_d = {STATUS_TAG, dq_s1_full, dq_s1_empty, dq_s0_full, dq_s0_empty};
          end
          OP_PUSH: begin
            if (tgt_full) begin
              rsp_data_d = RSP_PUSH_FULL;
            end else begin
              rsp_data_d   = RSP_PUSH_OK;
              dq_select_d  = sel;
              dq_data_in_d = cap_q;
              state_d      = StIssuePush;
            end
          end
          OP_POP: begin
            if (tgt_empty) begin
              rsp_data_d = RSP_POP_EMPTY;
            end else begin
              rsp_data_d  = RSP_POP_OK;
              two_d       = 1'b1;
              dq_select_d = sel;
              state_d     = StIssuePop;
            end
          end
          default: begin // OP_MOVE
            if (tgt_empty || oth_full) begin
              rsp_data_d = RSP_MOVE_ERR;
            end else begin
              rsp_data_d  = RSP_MOVE_OK;
              dq_select_d = sel;
              state_d     = StIssuePop;
            end
          end
        endcase
      end
      StIssuePop: begin
        cnt_d   = WaitInit;
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == 2'd0) begin
          cap_d = dq_data_out;
          if (op == OP_MOVE) begin
            dq_select_d  = ~sel;
            dq_data_in_d = dq_data_out;
            state_d      = StIssuePush;
          end else begin
            state_d = StResp;
          end
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      StIssuePush: begin
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          if (two_q) begin
            rsp_data_d = cap_q;
            state_d    = StResp2;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StResp2: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      op_q         <= 8'h00;
      cap_q        <= 8'h00;
      rsp_data_q   <= 8'h00;
      dq_select_q  <= 1'b0;
      dq_data_in_q <= 8'h00;
      cnt_q        <= 2'd0;
      two_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      cap_q        <= cap_d;
      rsp_data_q   <= rsp_data_d;
      dq_select_q  <= dq_select_d;
      dq_data_in_q <= dq_data_in_d;
      cnt_q        <= cnt_d;
      two_q        <= two_d;
    end
  end

  // Strobes decode straight from the state register so reset kills them at once
  assign cmd_ready  = (state_q == StIdle) || (state_q == StGetData);
  assign rsp_valid  = (state_q == StResp) || (state_q == StResp2);
  assign rsp_data   = rsp_data_q;
  assign dq_push    = (state_q == StIssuePush);
  assign dq_pop     = (state_q == StIssuePop);
  assign dq_select  = dq_select_q;
  assign dq_data_in = dq_data_in_q;

endmodule

// File: tb/tb_deque_cmd_host.sv
// Scoreboard bench for deque_cmd_host. One instance (POP_LATENCY=1) talks to a
// small behavioural deque model; a second instance (POP_LATENCY=3) checks
// latency and reset-abort behaviour against a fixed-flag stub.
module tb_deque_cmd_host;

  typedef struct packed {
    logic       is_push;
    logic       sel;
    logic [7:0] data;
  } strobe_t;

  int tests = 0;
  int fails = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance 1: POP_LATENCY = 1 ----------------
  logic       rst_n, cmd_valid, cmd_ready, rsp_valid, rsp_ready;
  logic [7:0] cmd_data, rsp_data, dq_data_in, dq_data_out;
  logic       dq_select, dq_push, dq_pop;
  logic       s0_empty, s0_full, s1_empty, s1_full;

  deque_cmd_host #(.POP_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .dq_select(dq_select), .dq_push(dq_push), .dq_pop(dq_pop),
    .dq_data_in(dq_data_in), .dq_data_out(dq_data_out),
    .dq_s0_empty(s0_empty), .dq_s0_full(s0_full),
    .dq_s1_empty(s1_empty), .dq_s1_full(s1_full)
  );

  // ---------------- instance 2: POP_LATENCY = 3 ----------------
  logic       rst3_n, cmd_valid3, cmd_ready3, rsp_valid3, rsp_ready3;
  logic [7:0] cmd_data3, rsp_data3, dq_data_in3, dq_data_out3;
  logic       dq_select3, dq_push3, dq_pop3;
  logic [2:0] pop_pipe3;

  deque_cmd_host #(.POP_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst3_n),
    .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_data(cmd_data3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3),
    .dq_select(dq_select3), .dq_push(dq_push3), .dq_pop(dq_pop3),
    .dq_data_in(dq_data_in3), .dq_data_out(dq_data_out3),
    .dq_s0_empty(1'b0), .dq_s0_full(1'b0),
    .dq_s1_empty(1'b1), .dq_s1_full(1'b0)
  );

  // Stub: data valid only in the cycle that ends 3 edges after the pop edge
  always @(posedge clk) pop_pipe3 <= {pop_pipe3[1:0], dq_pop3};
  assign dq_data_out3 = pop_pipe3[2] ? 8'h5A : 8'h00;

  // ---------------- checking helpers ----------------
  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // ---------------- deque model for instance 1 ----------------
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         n0 = 0, n1 = 0;
  logic       force_full0 = 1'b0;
  strobe_t    exp_strb[$];
  strobe_t    e_strb;
  logic       push_prev = 1'b0, prev_sel = 1'b0;
  logic [7:0] prev_data = 8'h00;

  assign s0_empty = (n0 == 0);
  assign s0_full  = (n0 >= 4) || force_full0;
  assign s1_empty = (n1 == 0);
  assign s1_full  = (n1 >= 4);

  always @(posedge clk) begin
    dq_data_out <= 8'h00;
    if (dq_push && dq_pop) check8("push_pop_overlap", 8'h01, 8'h00);
    if (push_prev) begin
      check8("push_hold_sel", {7'b0, dq_select}, {7'b0, prev_sel});
      check8("push_hold_data", dq_data_in, prev_data);
    end
    push_prev <= dq_push;
    prev_sel  <= dq_select;
    prev_data <= dq_data_in;
    if (dq_push || dq_pop) begin
      if (exp_strb.size() == 0) begin
        check8("unexpected_strobe", {6'b0, dq_push, dq_pop}, 8'h00);
      end else begin
        e_strb = exp_strb.pop_front();
        check8("strobe_kind", {7'b0, dq_push}, {7'b0, e_strb.is_push});
        check8("strobe_sel", {7'b0, dq_select}, {7'b0, e_strb.sel});
        if (e_strb.is_push) check8("strobe_data", dq_data_in, e_strb.data);
      end
      if (dq_push) begin
        if (dq_select) q1.push_back(dq_data_in);
        else q0.push_back(dq_data_in);
      end
      if (dq_pop) begin
        if (dq_select) begin
          if (q1.size() == 0) check8("pop_underflow_s1", 8'h01, 8'h00);
          else dq_data_out <= q1.pop_back();
        end else begin
          if (q0.size() == 0) check8("pop_underflow_s0", 8'h01, 8'h00);
          else dq_data_out <= q0.pop_back();
        end
      end
    end
    n0 <= q0.size();
    n1 <= q1.size();
  end

  // ---------------- response monitors ----------------
  logic [7:0] exp_rsp[$];
  logic [7:0] exp_rsp3[$];
  logic       no_strobe3 = 1'b0;

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_rsp.size() == 0) check8("unexpected_rsp", rsp_data, 8'hxx);
      else check8("rsp", rsp_data, exp_rsp.pop_front());
    end
    if (rst3_n && rsp_valid3 && rsp_ready3) begin
      if (exp_rsp3.size() == 0) check8("unexpected_rsp3", rsp_data3, 8'hxx);
      else check8("rsp3", rsp_data3, exp_rsp3.pop_front());
    end
    if (no_strobe3 && (dq_pop3 || dq_push3)) check8("strobe_after_reset3", 8'h01, 8'h00);
  end

  // ---------------- stimulus tasks ----------------
  task automatic send(input logic [7:0] b);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_data  = b;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check8("cmd_accept_timeout", 8'h00, 8'h01);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
  endtask

  task automatic send3(input logic [7:0] b);
    int n = 0;
    cmd_valid3 = 1'b1;
    cmd_data3  = b;
    @(negedge clk);
    while (!cmd_ready3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready3) check8("cmd3_accept_timeout", 8'h00, 8'h01);
    @(posedge clk);
    #1;
    cmd_valid3 = 1'b0;
    cmd_data3  = 8'h00;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_rsp.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (exp_rsp.size() != 0) begin
      check8("rsp_timeout", 8'(exp_rsp.size()), 8'h00);
      exp_rsp.delete();
    end
    @(posedge clk);
    #1;
    check8("strobes_pending", 8'(exp_strb.size()), 8'h00);
  endtask

  task automatic wait_done3();
    int n = 0;
    while (exp_rsp3.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (exp_rsp3.size() != 0) begin
      check8("rsp3_timeout", 8'(exp_rsp3.size()), 8'h00);
      exp_rsp3.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    rst_n = 1'b0; rst3_n = 1'b0;
    cmd_valid = 1'b0; cmd_data = 8'h00; rsp_ready = 1'b1;
    cmd_valid3 = 1'b0; cmd_data3 = 8'h00; rsp_ready3 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check8("reset_rsp_valid", {7'b0, rsp_valid}, 8'h00);
    check8("reset_rsp_data", rsp_data, 8'h00);
    check8("reset_strobes", {6'b0, dq_push, dq_pop}, 8'h00);
    check8("reset_select", {7'b0, dq_select}, 8'h00);
    check8("reset_data_in", dq_data_in, 8'h00);
    check8("reset_cmd_ready", {7'b0, cmd_ready}, 8'h01);
    rst_n = 1'b1; rst3_n = 1'b1;
    @(posedge clk);
    #1;

    // STATUS on empty deque
    exp_rsp.push_back(8'h55);
    send(8'h00);
    wait_done();

    // PUSH s0 A7, then POP s0
    exp_strb.push_back('{is_push: 1'b1, sel: 1'b0, data: 8'hA7});
    exp_rsp.push_back(8'h01);
    send(8'h40); send(8'hA7);
    wait_done();
    exp_strb.push_back('{is_push: 1'b0, sel: 1'b0, data: 8'h00});
    exp_rsp.push_back(8'h02); exp_rsp.push_back(8'hA7);
    send(8'h80);
    wait_done();

    // POP s1 on empty, reserved-bit opcode
    exp_rsp.push_back(8'hE2);
    send(8'h81);
    wait_done();
    exp_rsp.push_back(8'hEF);
    send(8'h42);
    wait_done();

    // PUSH s1 3C, MOVE s1 -> s0, STATUS
    exp_strb.push_back('{is_push: 1'b1, sel: 1'b1, data: 8'h3C});
    exp_rsp.push_back(8'h01);
    send(8'h41); send(8'h3C);
    wait_done();
    exp_strb.push_back('{is_push: 1'b0, sel: 1'b1, data: 8'h00});
    exp_strb.push_back('{is_push: 1'b1, sel: 1'b0, data: 8'h3C});
    exp_rsp.push_back(8'h03);
    send(8'hC1);
    wait_done();
    exp_rsp.push_back(8'h54); // s1 empty, s0 holds one entry
    send(8'h00);
    wait_done();

    // MOVE from empty s1 is refused
    exp_rsp.push_back(8'hE3);
    send(8'hC1);
    wait_done();

    // PUSH to full s0 with a 5-cycle response stall
    force_full0 = 1'b1;
    rsp_ready   = 1'b0;
    exp_rsp.push_back(8'hE1);
    send(8'h40); send(8'h11);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check8("stall_rsp_valid", {7'b0, rsp_valid}, 8'h01);
      check8("stall_rsp_data", rsp_data, 8'hE1);
      check8("stall_cmd_ready", {7'b0, cmd_ready}, 8'h00);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_done();
    force_full0 = 1'b0;
    check8("model_s0_count", 8'(q0.size()), 8'h01);
    check8("model_s1_count", 8'(q1.size()), 8'h00);

    // ---- POP_LATENCY = 3 instance ----
    exp_rsp3.push_back(8'h02); exp_rsp3.push_back(8'h5A);
    send3(8'h80);
    wait_done3();

    // Same POP, aborted by reset while waiting for data
    send3(8'h80);
    n = 0;
    while (!dq_pop3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check8("pop3_seen", {7'b0, dq_pop3}, 8'h01);
    @(posedge clk); // pop sampled, WAIT begins
    @(posedge clk);
    #3;
    rst3_n = 1'b0;
    no_strobe3 = 1'b1;
    #1;
    check8("abort_rsp_valid", {7'b0, rsp_valid3}, 8'h00);
    check8("abort_rsp_data", rsp_data3, 8'h00);
    check8("abort_strobes", {6'b0, dq_push3, dq_pop3}, 8'h00);
    check8("abort_select", {7'b0, dq_select3}, 8'h00);
    check8("abort_data_in", dq_data_in3, 8'h00);
    @(negedge clk);
    rst3_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    exp_rsp3.push_back(8'h54);
    send3(8'h00);
    wait_done3();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
